// File: rtl/elevator_car_ctrl_pkg.sv
// Shared constants and state encoding for the per-car motion/door sequencer.
// Floor codes run 1..NUM_FLOORS; code 0 means "no floor".
package elevator_car_ctrl_pkg;

  localparam int NUM_FLOORS = 7;
  localparam int FLOOR_W    = 3;
  localparam int CNT_W      = 4;

  localparam logic [FLOOR_W-1:0] FLOOR_NONE = '0;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_EVAL = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

endpackage

// File: rtl/elevator_car_ctrl_dwell_counter.sv
// Tick-strobe dwell counter shared by the MOVE and DOOR phases.
// Ports: clk, rst, clear (hold at 0), tick, limit, done (limit-th tick).
module elevator_car_ctrl_dwell_counter
  import elevator_car_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == (limit - 1'b1));
  assign done   = tick & ~clear & w_last;

  always_ff @(posedge clk) begin
    if (rst || clear || done) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/elevator_car_ctrl.sv
// Per-car sequencer: floor, direction, door and dwell timing.
// Ports: clk/rst/tick/turn, hall calls, boarding slots in; floor,
// dir, door_open, moving, clr_up/clr_down/alight pulses out.
module elevator_car_ctrl
  import elevator_car_ctrl_pkg::*;
#(
  parameter int MOVE_TICKS = 2,
  parameter int DOOR_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  turn,
  input  logic [NUM_FLOORS-1:0] up_passenger,
  input  logic [NUM_FLOORS-1:0] down_passenger,
  input  logic [5:0]            boarding,
  output logic [FLOOR_W-1:0]    curr_floor,
  output logic                  dir,
  output logic                  door_open,
  output logic                  moving,
  output logic [NUM_FLOORS-1:0] clr_up,
  output logic [NUM_FLOORS-1:0] clr_down,
  output logic [1:0]            alight
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [FLOOR_W-1:0]    r_floor;
  logic [FLOOR_W-1:0]    w_floor_nxt;
  logic                  r_dir;
  logic                  w_dir_nxt;
  logic                  r_door;
  logic                  r_moving;
  logic [NUM_FLOORS-1:0] r_clr_up;
  logic [NUM_FLOORS-1:0] r_clr_down;
  logic [1:0]            r_alight;
  logic [NUM_FLOORS-1:0] w_clr_up;
  logic [NUM_FLOORS-1:0] w_clr_down;
  logic [1:0]            w_alight;

  logic                  w_clear;
  logic                  w_done;
  logic [CNT_W-1:0]      w_limit;

  logic [NUM_FLOORS-1:0] w_here;
  logic [NUM_FLOORS-1:0] w_above;
  logic [NUM_FLOORS-1:0] w_below;
  logic [NUM_FLOORS-1:0] w_req;
  logic [FLOOR_W-1:0]    w_slot0;
  logic [FLOOR_W-1:0]    w_slot1;
  logic [1:0]            w_match;
  logic                  w_pend;
  logic                  w_stop;
  logic                  w_ahead;
  logic                  w_edge;

  // Counter idles cleared in EVAL, so a tick there never counts.
  assign w_clear = (r_state == ST_EVAL);
  assign w_limit = (r_state == ST_MOVE) ? CNT_W'(MOVE_TICKS)
                                        : CNT_W'(DOOR_TICKS);

  elevator_car_ctrl_dwell_counter u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .tick  (tick),
    .limit (w_limit),
    .done  (w_done)
  );

  // Floor masks: bit f-1 is floor f.
  assign w_here  = NUM_FLOORS'(1) << (r_floor - 1'b1);
  assign w_above = ~((NUM_FLOORS'(1) << r_floor) - NUM_FLOORS'(1));
  assign w_below = w_here - NUM_FLOORS'(1);
  assign w_req   = up_passenger | down_passenger;

  assign w_slot0 = boarding[2:0];
  assign w_slot1 = boarding[5:3];
  assign w_match[0] = (w_slot0 != FLOOR_NONE) && (w_slot0 == r_floor);
  assign w_match[1] = (w_slot1 != FLOOR_NONE) && (w_slot1 == r_floor);

  assign w_pend = (|w_req) | (|boarding);

  assign w_stop = (r_dir & |(up_passenger & w_here))
                | (~r_dir & |(down_passenger & w_here))
                | (|w_match);

  assign w_ahead = (r_dir ? |(w_req & w_above) : |(w_req & w_below))
                 | (|boarding);

  assign w_edge = (r_dir  && r_floor == FLOOR_W'(NUM_FLOORS))
               || (!r_dir && r_floor == FLOOR_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_floor_nxt = r_floor;
    w_dir_nxt   = r_dir;
    w_clr_up    = '0;
    w_clr_down  = '0;
    w_alight    = '0;
    unique case (r_state)
      ST_EVAL: begin
        if (w_stop) begin
          w_state_nxt = ST_DOOR;
          w_clr_up    = r_dir ? w_here : '0;
          w_clr_down  = r_dir ? '0 : w_here;
          w_alight    = w_match;
        end else if (turn && w_pend) begin
          w_dir_nxt = ~r_dir;
        end else if (w_edge && w_pend) begin
          // Turn around at the shaft ends so the floor stays in range.
          w_dir_nxt = ~r_dir;
        end else if (w_ahead) begin
          w_state_nxt = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (w_done) begin
          w_state_nxt = ST_EVAL;
          w_floor_nxt = (r_dir == DIR_DOWN) ? r_floor - 1'b1
                                            : r_floor + 1'b1;
        end
      end
      ST_DOOR: begin
        if (w_done) begin
          w_state_nxt = ST_EVAL;
        end
      end
      default: begin
        w_state_nxt = ST_EVAL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EVAL;
      r_floor    <= FLOOR_W'(1);
      r_dir      <= DIR_UP;
      r_door     <= 1'b0;
      r_moving   <= 1'b0;
      r_clr_up   <= '0;
      r_clr_down <= '0;
      r_alight   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_floor    <= w_floor_nxt;
      r_dir      <= w_dir_nxt;
      r_door     <= (w_state_nxt == ST_DOOR);
      r_moving   <= (w_state_nxt == ST_MOVE);
      r_clr_up   <= w_clr_up;
      r_clr_down <= w_clr_down;
      r_alight   <= w_alight;
    end
  end

  assign curr_floor = r_floor;
  assign dir        = r_dir;
  assign door_open  = r_door;
  assign moving     = r_moving;
  assign clr_up     = r_clr_up;
  assign clr_down   = r_clr_down;
  assign alight     = r_alight;

endmodule
